// File: rtl/lut_12bit_1s_pkg.sv
// Shared widths and the nibble popcount table for the 12-bit ones counter.
package lut_12bit_1s_pkg;

    localparam int unsigned DATA_W   = 12;
    localparam int unsigned COUNT_W  = 4;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned NUM_NIB  = DATA_W / NIBBLE_W;
    localparam int unsigned PART_W   = 3;

    // Entry i holds the number of set bits in the 4-bit value i.
    localparam logic [PART_W-1:0] NIBBLE_POP_TABLE [16] = '{
        3'd0, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd2, 3'd3,
        3'd1, 3'd2, 3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd4
    };

endpackage

// File: rtl/lut_12bit_1s_nibble_popcount_lut.sv
// Purely combinational 16-entry lookup: number of 1s in a 4-bit nibble.
module nibble_popcount_lut
    import lut_12bit_1s_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [PART_W-1:0]   pop_o
);

    assign pop_o = NIBBLE_POP_TABLE[nibble_i];

endmodule

// File: rtl/lut_12bit_1s.sv
// Registered 12-bit population count built from three nibble lookups and an adder.
module lut_12bit_1s
    import lut_12bit_1s_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  bits,
    output logic [COUNT_W-1:0] count,
    output logic               out_valid
);

    logic [PART_W-1:0]  part [NUM_NIB];
    logic [COUNT_W-1:0] sum;
    logic [COUNT_W-1:0] count_d, count_q;
    logic               out_valid_d, out_valid_q;

    for (genvar g = 0; g < NUM_NIB; g++) begin : g_nib
        nibble_popcount_lut u_lut (
            .nibble_i (bits[g*NIBBLE_W +: NIBBLE_W]),
            .pop_o    (part[g])
        );
    end

    // Max 4+4+4 = 12 fits in 4 bits, so zero-extended partials never overflow.
    assign sum = {1'b0, part[0]} + {1'b0, part[1]} + {1'b0, part[2]};

    always_comb begin
        count_d     = count_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            count_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign count     = count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_lut_12bit_1s.sv
// Randomized and directed checks of lut_12bit_1s against a popcount reference model.
module tb_lut_12bit_1s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] bits;
    logic [3:0]  count;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the outputs should show after the last edge.
    int model_count = 0;
    int model_valid = 0;

    lut_12bit_1s dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .bits      (bits),
        .count     (count),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_pop(input logic [11:0] b);
        return $countones(b);
    endfunction

    // Drive one word, clock it, then compare outputs against the model.
    task automatic step(input string tag, input logic v, input logic [11:0] b);
        in_valid = v;
        bits     = b;
        @(posedge clk);
        if (v) model_count = ref_pop(b);
        model_valid = v ? 1 : 0;
        #1;
        check({tag, ".count"}, int'(count), model_count);
        check({tag, ".valid"}, int'(out_valid), model_valid);
    endtask

    // Assert reset between edges with a word presented, then release cleanly.
    task automatic mid_reset(input string tag, input logic [11:0] b);
        in_valid = 1'b1;
        bits     = b;
        #2;
        rst_n = 1'b0;
        #1;
        model_count = 0;
        model_valid = 0;
        check({tag, ".async_count"}, int'(count), 0);
        check({tag, ".async_valid"}, int'(out_valid), 0);
        @(posedge clk);
        #1;
        check({tag, ".held_count"}, int'(count), 0);
        check({tag, ".held_valid"}, int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step({tag, ".post"}, 1'b0, 12'hFFF);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        bits     = 12'hFFF;
        #3;
        check("reset.count", int'(count), 0);
        check("reset.valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("reset_edge.count", int'(count), 0);
        check("reset_edge.valid", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step("idle", 1'b0, 12'h000);

        step("all_ones", 1'b1, 12'b111111111111);
        check("all_ones.is12", int'(count), 12);
        step("pat_a", 1'b1, 12'b010110101101);
        check("pat_a.is7", int'(count), 7);
        step("pat_b", 1'b1, 12'b100001011100);
        check("pat_b.is5", int'(count), 5);
        step("zero", 1'b1, 12'h000);
        step("hold", 1'b0, 12'hFFF);
        check("hold.is0", int'(count), 0);

        // Back-to-back sweep of every input value.
        for (int i = 0; i < 4096; i++) begin
            step("sweep", 1'b1, 12'(i));
        end

        step("pre_rst", 1'b1, 12'hFFF);
        mid_reset("rst_mid", 12'hABC);

        // Random valid/data mix with occasional mid-cycle resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                mid_reset("rand_rst", 12'($urandom));
            end else begin
                step("rand", 1'($urandom_range(0, 3) != 0), 12'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
